my_not_pipe: RTL
================

// Module: my_not_pipe
// PURPOSE
//   Parametrised, pipelined successor to the single-bit NOT gate. Inverts a WIDTH-bit bus
//   through STAGES register stages under valid/ready flow control.
//   Selectable mode: pass, full invert, masked invert, or alternate-beat invert.
//   Sits between a streaming source and sink; counts delivered beats for bench/debug.
// PARAMETERS
//   WIDTH   8   data bus width in bits (>=1)
//   STAGES  2   pipeline register stages, accept-to-output latency (>=1)
// PORTS
//   clk        in   1      sole clock, all logic on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      upstream beat present
//   in_ready   out  1      block can accept a beat this cycle
//   in_data    in   WIDTH  upstream data
//   mode       in   2      00 pass, 01 invert all, 10 invert where mask=1, 11 invert odd beats
//   mask       in   WIDTH  per-bit invert mask, used in mode 10 only
//   out_valid  out  1      downstream beat present
//   out_ready  in   1      downstream accepts this cycle
//   out_data   out  WIDTH  transformed data
//   beat_cnt   out  16     count of completed output transfers, saturating
// BEHAVIOUR
//   Reset (rst=1 at posedge): all stage valids=0, all stage data=0, out_valid=0,
//     out_data=0, beat_cnt=0, odd-beat toggle=0. in_ready may be 1 during reset,
//     but no beat is accepted while rst=1. Reset mid-stream drops all in-flight beats.
//   Transfer rules: input transfer when in_valid&&in_ready.
//     Output transfer when out_valid&&out_ready.
//   Transform applied at input acceptance (stage 0); later stages only carry data.
//     mode/mask sampled with the beat. Mode changes never alter beats already in flight.
//     00: d; 01: ~d; 10: d ^ mask; 11: toggle ? ~d : d.
//   Odd-beat toggle: flips on every input transfer, regardless of mode.
//     First accepted beat after reset is beat 0 (even, passed).
//   Pipeline: STAGES registers, each with a valid bit.
//     Stage k loads from k-1 when stage k is empty, or when stage k's contents move on
//     the same cycle. Stage STAGES-1 moves on an output transfer.
//     Holding a stage keeps its data and valid stable.
//   Ready chain is combinational from out_ready back to in_ready.
//     A stage is ready when it is empty or when its successor moves this cycle.
//     No combinational path from in_valid/in_data to out_*.
//   Latency: a beat accepted at edge N appears on out_valid/out_data after edge N+STAGES-1,
//     provided out_ready stays 1.
//   Throughput: 1 beat/cycle with out_ready=1. Bubbles collapse when downstream stalls.
//   Full: all stages valid and out_ready=0 -> in_ready=0; contents, toggle and beat_cnt frozen.
//   Empty: out_valid=0; out_data holds its last value (don't-care to sink).
//   Simultaneous accept and deliver when full: both occur and occupancy is unchanged.
//   out_valid never drops without a transfer. out_data is stable while out_valid&&!out_ready.
//   beat_cnt: +1 per output transfer; saturates at 16'hFFFF; no wrap.
// TESTING
//   T1: WIDTH=1, mode=01, out_ready=1, in 0 then 1 -> out 1 then 0, each STAGES cycles
//       after accept (legacy NOT check).
//   T2: WIDTH=8, mode=01, stream 8'h00,8'hA5,8'hFF back-to-back -> 8'hFF,8'h5A,8'h00
//       on consecutive cycles; beat_cnt=3.
//   T3: mode=10, mask=8'h0F, in 8'h3C -> 8'h33. Mode changed to 00 while the beat is in
//       flight -> output still 8'h33.
//   T4: mode=11, four beats of 8'h55 -> 8'h55,8'hAA,8'h55,8'hAA.
//   T5: out_ready=0 for 10 cycles with in_valid=1 -> exactly STAGES beats accepted,
//       in_ready=0, out_data stable. Release -> all beats delivered in order, no loss or duplicate.
//   T6: rst pulse while 2 beats in flight -> next cycle out_valid=0, beat_cnt=0; next beat
//       accepted is treated as even. Force beat_cnt to 16'hFFFF then transfer -> stays 16'hFFFF.

Source files
------------

// File: rtl/my_not_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : my_not_pipe                                                |
// | Description : Pipelined WIDTH-bit inverter with valid/ready flow control,|
// |               selectable transform mode and a saturating beat counter.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module my_not_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [15:0]      beat_cnt
);

   localparam logic [1:0]  c_MODE_PASS   = 2'b00;
   localparam logic [1:0]  c_MODE_INV    = 2'b01;
   localparam logic [1:0]  c_MODE_MASK   = 2'b10;
   localparam logic [1:0]  c_MODE_ODD    = 2'b11;
   localparam logic [15:0] c_CNT_MAX     = 16'hFFFF;

   // Per-stage state: one valid bit and one data word per register stage.
   logic [STAGES-1:0] valid_q, valid_d;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic              toggle_q, toggle_d;
   logic [15:0]       beat_cnt_q, beat_cnt_d;

   // w_ready[k] : stage k can take a new word this cycle; w_ready[STAGES] is the sink.
   logic [STAGES:0]   w_ready;
   logic              w_in_fire;
   logic              w_out_fire;
   logic [WIDTH-1:0]  w_xform;

   // Ready chain: a stage is ready when empty or when its contents leave this cycle.
   always_comb begin
      w_ready          = '0;
      w_ready[STAGES]  = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_ready[k] = !valid_q[k] || w_ready[k+1];
      end
   end

   assign w_in_fire  = in_valid && w_ready[0];
   assign w_out_fire = valid_q[STAGES-1] && out_ready;

   // Transform applied once, at acceptance; later stages only carry the result.
   always_comb begin
      w_xform = in_data;
      case (mode)
         c_MODE_PASS: w_xform = in_data;
         c_MODE_INV:  w_xform = ~in_data;
         c_MODE_MASK: w_xform = in_data ^ mask;
         c_MODE_ODD:  w_xform = toggle_q ? ~in_data : in_data;
         default:     w_xform = in_data;
      endcase
   end

   // Next-state: advance stages that are ready, keep the rest, update toggle and counter.
   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      toggle_d   = toggle_q;
      beat_cnt_d = beat_cnt_q;

      // Stage 0 takes from the upstream port.
      if (w_ready[0]) begin
         valid_d[0] = in_valid;
         if (in_valid) begin
            data_d[0] = w_xform;
         end
      end

      // Later stages take from their predecessor; data only moves with a valid word
      // so an emptied output stage still shows its last value.
      for (int k = 1; k < STAGES; k++) begin
         if (w_ready[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end

      if (w_in_fire) begin
         toggle_d = ~toggle_q;
      end

      if (w_out_fire && (beat_cnt_q != c_CNT_MAX)) begin
         beat_cnt_d = beat_cnt_q + 16'd1;
      end
   end

   // State registers with synchronous reset that drops every in-flight beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         toggle_q   <= 1'b0;
         beat_cnt_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         toggle_q   <= toggle_d;
         beat_cnt_q <= beat_cnt_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign in_ready  = w_ready[0];
   assign out_valid = valid_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];
   assign beat_cnt  = beat_cnt_q;

endmodule
`default_nettype wire
